// File: rtl/ntp_exec_ctrl.sv
// ntp_exec_ctrl: multi-cycle fetch/decode/execute/writeback sequencer for the
// 8-bit NTP core. Owns the PC, instruction register, operand latches, the
// architectural flags, the OUT port and the instruction/data memory handshakes.
module ntp_exec_ctrl #(
  parameter int              PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  // instruction fetch
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  // register file
  output logic [2:0]      rf_ra,
  output logic [2:0]      rf_rb,
  input  logic [7:0]      rf_da,
  input  logic [7:0]      rf_db,
  output logic            rf_we,
  output logic [2:0]      rf_wa,
  output logic [7:0]      rf_wd,
  // ALU
  output logic [4:0]      op_dec,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [7:0]      ans_ex,
  input  logic [7:0]      ans_tmp,
  input  logic [3:0]      flag_ex,
  // data memory
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [7:0]      dmem_addr,
  output logic [7:0]      dmem_wdata,
  input  logic            dmem_ack,
  input  logic [7:0]      dmem_rdata,
  // architectural state
  output logic [7:0]      data_out,
  output logic [3:0]      flags,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  localparam logic [4:0] OP_NOP = 5'b10001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [15:0] ir_reg;
  logic [7:0]  opa_reg;
  logic [7:0]  opb_reg;
  logic [7:0]  res_reg;

  // Instruction fields
  logic [4:0] opcode;
  logic [2:0] rd;
  logic [2:0] rs;
  logic [7:0] imm8;

  assign opcode = ir_reg[15:11];
  assign rd     = ir_reg[10:8];
  assign rs     = ir_reg[7:5];
  assign imm8   = ir_reg[7:0];

  // Opcode class decode
  logic is_undef;
  logic is_alu;
  logic is_ld;
  logic is_st;
  logic is_in;
  logic is_out;
  logic is_shift;
  logic is_jmp;
  logic is_hlt;
  logic is_jcc;
  logic use_imm;
  logic writes_res;
  logic jcc_taken;
  logic take_branch;

  assign is_undef   = (opcode == 5'b00011) || (opcode == 5'b01011) ||
                      (opcode == 5'b10010) || (opcode == 5'b10011);
  assign is_alu     = !opcode[4] && !is_undef;
  assign is_ld      = (opcode == 5'b10100);
  assign is_st      = (opcode == 5'b10101);
  assign is_in      = (opcode == 5'b10110);
  assign is_out     = (opcode == 5'b10111);
  assign is_shift   = (opcode == 5'b11001) || (opcode == 5'b11010) ||
                      (opcode == 5'b11011);
  assign is_jmp     = (opcode == 5'b10000);
  assign is_hlt     = (opcode == 5'b11000);
  assign is_jcc     = (opcode[4:2] == 3'b111);
  // Immediate class is 01xxx: operand B comes from imm8 instead of rs.
  assign use_imm    = opcode[3] && !opcode[4];
  assign writes_res = is_alu || is_in || is_shift;
  // JC/JZ/JV/JP test flag bit 0/1/2/3, i.e. the low two opcode bits.
  // Flags here are the pre-EXEC value because they only update on result ops.
  assign jcc_taken  = flags[opcode[1:0]];
  assign take_branch = is_jmp || (is_jcc && jcc_taken);

  // Datapath outputs that are simply views of latched state
  assign imem_addr  = pc;
  assign rf_ra      = rd;
  assign rf_rb      = rs;
  assign rf_wa      = rd;
  assign rf_wd      = res_reg;
  assign alu_a      = opa_reg;
  assign alu_b      = opb_reg;
  assign dmem_addr  = opb_reg;
  assign dmem_wdata = opa_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-state strobes; strobes decode from state only so
  // an asynchronous reset drops them in the same cycle.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    op_dec     = OP_NOP;
    halted     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (run) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        op_dec = opcode;
        if (writes_res) begin
          state_next = S_WB;
        end else if (is_ld || is_st) begin
          state_next = S_MEM;
        end else if (is_hlt) begin
          state_next = S_HALT;
        end else begin
          // OUT, JMP, Jcc, NOP and undefined opcodes all return to fetch
          state_next = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        if (dmem_ack) begin
          state_next = is_ld ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (run) begin
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers: IR, PC, operand latches, result, flags, OUT port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RST_PC;
      ir_reg   <= 16'h0000;
      opa_reg  <= 8'h00;
      opb_reg  <= 8'h00;
      res_reg  <= 8'h00;
      ans_ex   <= 8'h00;
      data_out <= 8'h00;
      flags    <= 4'h0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (imem_ack) begin
            ir_reg <= imem_data;
            pc     <= pc + PC_W'(1);
          end
        end
        S_DECODE: begin
          opa_reg <= rf_da;
          opb_reg <= use_imm ? imm8 : rf_db;
        end
        S_EXEC: begin
          if (writes_res) begin
            res_reg <= ans_tmp;
            flags   <= flag_ex;
          end
          if (is_out) begin
            data_out <= opa_reg;
          end
          if (take_branch) begin
            pc <= PC_W'(imm8);
          end
        end
        S_MEM: begin
          if (dmem_ack && is_ld) begin
            res_reg <= dmem_rdata;
          end
        end
        S_WB: begin
          ans_ex <= res_reg;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
